// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID pipeline register of the 5-stage RV32I core.
// It owns the fetch PC, drives the instruction ROM address, and holds the IF/ID
// register. The run/step controller produces run_en, which gates fetching.
//
// Redirect handshake: redirect_valid is a single-cycle request from EX that carries
// redirect_pc. There is no ready; the stage always accepts a redirect in the cycle
// it is presented. A redirect overrides any stall on both the PC and IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP         = 32'h0000_0013,
    parameter int          IMEM_AW     = 8,
    parameter logic [31:0] COUNT_RESET = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
    input  logic               step,
    input  logic               f_stall,
    input  logic               d_stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        pc_f,
    output logic [31:0]        ir_d,
    output logic [31:0]        pc_d,
    output logic               valid_d,
    output logic               run_en,
    output logic [31:0]        fetch_count,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        step_q;
    logic        step_rise;
    logic        fe;
    logic        load;
    logic [31:0] pc_next;
    logic [31:0] ir_next;
    logic [31:0] pc_d_next;
    logic        valid_next;
    logic [31:0] count_next;

    // The two low redirect bits are discarded: targets are always word aligned.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // ROM word address is taken straight from the fetch PC.
    assign imem_addr = pc_f[IMEM_AW+1:2];

    // Controller outputs: any non-idle state enables fetching.
    assign run_en    = (state != S_IDLE);
    assign dbg_state = state;
    assign step_rise = step & ~step_q;

    // Fetch enable, and a "real instruction enters IF/ID" flag used by the
    // counter and by the single-step controller.
    assign fe   = run_en & ~f_stall;
    assign load = ~redirect_valid & ~d_stall & fe;

    // Controller state and step edge detector registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state  <= S_IDLE;
            step_q <= 1'b0;
        end else begin
            state  <= state_next;
            step_q <= step;
        end
    end

    // Controller next state. STEP only leaves once an instruction has actually
    // loaded, so a stalled step waits rather than being lost. Step edges outside
    // IDLE are ignored; run seen during STEP is honoured from IDLE afterwards.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (run) begin
                    state_next = S_RUN;
                end else if (step_rise) begin
                    state_next = S_STEP;
                end
            end
            S_RUN: begin
                if (!run) begin
                    state_next = S_IDLE;
                end
            end
            S_STEP: begin
                if (load) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Next fetch PC: redirect beats stall, stall beats sequential advance.
    // Sequential advance wraps naturally at 32 bits.
    always_comb begin
        pc_next = pc_f;
        if (redirect_valid) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if (f_stall) begin
            pc_next = pc_f;
        end else if (run_en) begin
            pc_next = pc_f + 32'd4;
        end
    end

    // Next IF/ID contents: redirect flushes (keeping pc_d), d_stall holds,
    // no fetch inserts a bubble, otherwise capture the ROM word and its PC.
    always_comb begin
        ir_next    = ir_d;
        pc_d_next  = pc_d;
        valid_next = valid_d;
        if (redirect_valid) begin
            ir_next    = NOP;
            valid_next = 1'b0;
        end else if (d_stall) begin
            ir_next    = ir_d;
            pc_d_next  = pc_d;
            valid_next = valid_d;
        end else if (!fe) begin
            ir_next    = NOP;
            valid_next = 1'b0;
        end else begin
            ir_next    = imem_data;
            pc_d_next  = pc_f;
            valid_next = 1'b1;
        end
    end

    // Saturating count of real instructions loaded into IF/ID.
    always_comb begin
        count_next = fetch_count;
        if (load && (fetch_count != 32'hFFFF_FFFF)) begin
            count_next = fetch_count + 32'd1;
        end
    end

    // PC, IF/ID and counter registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_f        <= RESET_PC;
            ir_d        <= NOP;
            pc_d        <= 32'h0000_0000;
            valid_d     <= 1'b0;
            fetch_count <= COUNT_RESET;
        end else begin
            pc_f        <= pc_next;
            ir_d        <= ir_next;
            pc_d        <= pc_d_next;
            valid_d     <= valid_next;
            fetch_count <= count_next;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by a randomized phase,
// all checked every cycle against a behavioural model of the fetch stage.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        rstn;
    logic        run;
    logic        step;
    logic        f_stall;
    logic        d_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc_f;
    logic [31:0] ir_d;
    logic [31:0] pc_d;
    logic        valid_d;
    logic        run_en;
    logic [31:0] fetch_count;
    logic [1:0]  dbg_state;

    // Second instance whose counter starts near the top, to reach saturation.
    logic [7:0]  s_imem_addr;
    logic [31:0] s_imem_data;
    logic [31:0] s_pc_f;
    logic [31:0] s_ir_d;
    logic [31:0] s_pc_d;
    logic        s_valid_d;
    logic        s_run_en;
    logic [31:0] s_fetch_count;
    logic [1:0]  s_dbg_state;

    logic [31:0] rom [0:255];
    assign imem_data   = rom[imem_addr];
    assign s_imem_data = rom[s_imem_addr];

    fetch_stage dut (
        .clk(clk), .rstn(rstn), .run(run), .step(step),
        .f_stall(f_stall), .d_stall(d_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .pc_f(pc_f), .ir_d(ir_d), .pc_d(pc_d), .valid_d(valid_d),
        .run_en(run_en), .fetch_count(fetch_count), .dbg_state(dbg_state)
    );

    fetch_stage #(.COUNT_RESET(32'hFFFF_FFFE)) dut_sat (
        .clk(clk), .rstn(rstn), .run(run), .step(step),
        .f_stall(f_stall), .d_stall(d_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(s_imem_addr), .imem_data(s_imem_data),
        .pc_f(s_pc_f), .ir_d(s_ir_d), .pc_d(s_pc_d), .valid_d(s_valid_d),
        .run_en(s_run_en), .fetch_count(s_fetch_count), .dbg_state(s_dbg_state)
    );

    // ---------------- reference model ----------------
    // Mode of the core: 0 halted, 1 free running, 2 single-stepping.
    int          m_mode;
    logic        m_prev_step;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_pcd;
    logic        m_valid;
    logic [31:0] m_cnt;
    logic [31:0] m_cnt_sat;

    task automatic model_edge();
        bit          fetching;
        bit          accepted;
        logic [31:0] word;
        if (!rstn) begin
            m_mode      = 0;
            m_prev_step = 1'b0;
            m_pc        = 32'h0;
            m_ir        = NOP;
            m_pcd       = 32'h0;
            m_valid     = 1'b0;
            m_cnt       = 32'h0;
            m_cnt_sat   = 32'hFFFF_FFFE;
        end else begin
            fetching = (m_mode != 0) && !f_stall;
            accepted = fetching && !redirect_valid && !d_stall;
            word     = rom[m_pc[9:2]];
            if (redirect_valid) begin
                m_ir    = NOP;
                m_valid = 1'b0;
            end else if (!d_stall) begin
                m_ir    = fetching ? word : NOP;
                m_valid = fetching;
                if (fetching) m_pcd = m_pc;
            end
            if (redirect_valid) m_pc = redirect_pc & 32'hFFFF_FFFC;
            else if (fetching)  m_pc = m_pc + 32'd4;
            if (accepted) begin
                if (m_cnt != 32'hFFFF_FFFF)     m_cnt     = m_cnt + 1;
                if (m_cnt_sat != 32'hFFFF_FFFF) m_cnt_sat = m_cnt_sat + 1;
            end
            if (m_mode == 0) begin
                if (run) m_mode = 1;
                else if (step && !m_prev_step) m_mode = 2;
            end else if (m_mode == 1) begin
                if (!run) m_mode = 0;
            end else begin
                if (accepted) m_mode = 0;
            end
            m_prev_step = step;
        end
    endtask

    // ---------------- scoreboard ----------------
    int compared;
    int mismatched;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc_f", pc_f, m_pc);
        chk("imem_addr", {24'h0, imem_addr}, {24'h0, m_pc[9:2]});
        chk("ir_d", ir_d, m_ir);
        chk("pc_d", pc_d, m_pcd);
        chk("valid_d", {31'h0, valid_d}, {31'h0, m_valid});
        chk("run_en", {31'h0, run_en}, (m_mode != 0) ? 32'h1 : 32'h0);
        chk("fetch_count", fetch_count, m_cnt);
        chk("sat_fetch_count", s_fetch_count, m_cnt_sat);
    endtask

    // ---------------- driver ----------------
    // One clock: model advances at the rising edge, outputs checked at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic tickn(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        compared       = 0;
        mismatched     = 0;
        rstn           = 1'b0;
        run            = 1'b0;
        step           = 1'b0;
        f_stall        = 1'b0;
        d_stall        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        for (int i = 0; i < 256; i++) rom[i] = i + 1;

        // Reset state
        tickn(2);
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_ir", ir_d, NOP);
        chk("rst_valid", {31'h0, valid_d}, 32'h0);
        chk("rst_run_en", {31'h0, run_en}, 32'h0);
        chk("rst_count", fetch_count, 32'h0);

        // 1: free run, ROM[i]=i+1
        rstn = 1'b1;
        run  = 1'b1;
        tick();
        chk("t1_c1_pc", pc_f, 32'h0);
        chk("t1_c1_valid", {31'h0, valid_d}, 32'h0);
        tick();
        chk("t1_c2_pc", pc_f, 32'h4);
        chk("t1_c2_ir", ir_d, 32'h1);
        chk("t1_c2_valid", {31'h0, valid_d}, 32'h1);
        tick();
        chk("t1_c3_pc", pc_f, 32'h8);
        chk("t1_c3_ir", ir_d, 32'h2);

        // 2: both stalls for two cycles at pc_f=8
        f_stall = 1'b1;
        d_stall = 1'b1;
        tickn(2);
        chk("t2_hold_pc", pc_f, 32'h8);
        chk("t2_hold_ir", ir_d, 32'h2);
        chk("t2_hold_pcd", pc_d, 32'h4);
        f_stall = 1'b0;
        d_stall = 1'b0;
        tick();
        chk("t2_rel_pc", pc_f, 32'hC);
        chk("t2_rel_ir", ir_d, 32'h3);
        chk("t2_count3", fetch_count, 32'h3);

        // 3: redirect together with f_stall
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        f_stall        = 1'b1;
        tick();
        chk("t3_pc", pc_f, 32'h40);
        chk("t3_ir", ir_d, NOP);
        chk("t3_valid", {31'h0, valid_d}, 32'h0);
        chk("t3_pcd", pc_d, 32'h8);
        redirect_valid = 1'b0;
        f_stall        = 1'b0;
        tick();
        chk("t3_ir_next", ir_d, 32'h11);
        chk("t3_pcd_next", pc_d, 32'h40);

        // 4: stop, single step, held step, step while running
        run = 1'b0;
        tickn(2);
        chk("t4_idle_pc", pc_f, 32'h48);
        chk("t4_idle_valid", {31'h0, valid_d}, 32'h0);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("t4_step_ir", ir_d, 32'h13);
        chk("t4_step_valid", {31'h0, valid_d}, 32'h1);
        chk("t4_step_count", fetch_count, 32'h6);
        chk("t4_step_idle", {31'h0, run_en}, 32'h0);
        tick();
        step = 1'b1;
        tickn(5);
        chk("t4_held_count", fetch_count, 32'h7);
        chk("t4_held_pc", pc_f, 32'h50);
        step = 1'b0;
        run  = 1'b1;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("t4_run_pc", pc_f, 32'h58);
        chk("t4_run_count", fetch_count, 32'h9);
        chk("t4_run_en", {31'h0, run_en}, 32'h1);

        // 5: reset in the middle of a run at pc_f=0x20
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick();
        chk("t5_pc20", pc_f, 32'h20);
        redirect_valid = 1'b0;
        rstn           = 1'b0;
        tick();
        chk("t5_pc", pc_f, 32'h0);
        chk("t5_valid", {31'h0, valid_d}, 32'h0);
        chk("t5_run_en", {31'h0, run_en}, 32'h0);
        chk("t5_count", fetch_count, 32'h0);

        // 6: PC wrap and counter saturation
        rstn           = 1'b1;
        run            = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        chk("t6_pc_top", pc_f, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        run            = 1'b1;
        tick();
        chk("t6_addr", {24'h0, imem_addr}, 32'hFF);
        tick();
        chk("t6_wrap_pc", pc_f, 32'h0);
        chk("t6_wrap_ir", ir_d, 32'h100);
        chk("t6_wrap_pcd", pc_d, 32'hFFFF_FFFC);
        chk("t6_sat1", s_fetch_count, 32'hFFFF_FFFF);
        tickn(2);
        chk("t6_sat2", s_fetch_count, 32'hFFFF_FFFF);
        chk("t6_count", fetch_count, 32'h3);

        // Randomized phase against the model
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        for (int c = 0; c < 600; c++) begin
            rstn           = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 11) == 0) run = ~run;
            step           = ($urandom_range(0, 5) == 0);
            f_stall        = ($urandom_range(0, 4) == 0);
            d_stall        = ($urandom_range(0, 4) == 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc    = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
